decode_window_ctrl: RTL and testbench

Front-end byte-stream controller that sits between instruction fetch and the combinational x86 decoder. It owns a 32-byte circular instruction-byte buffer and requests 8-byte fetch chunks from the current fetch address. It presents the oldest 15 bytes as the decode window, together with the PC of that window's first byte, and retires exactly the byte count the decoder reports. It also handles branch redirects and stops on an invalid-opcode report.

---
 rtl/decode_window_ctrl_pkg.sv | 21 ++
 rtl/decode_window_ctrl_byte_ring_buffer.sv | 37 +++
 rtl/decode_window_ctrl.sv | 110 +++++++++++
 tb/tb_decode_window_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_window_ctrl_pkg.sv
// Shared constants and types for the instruction-byte front end that feeds
// the combinational x86 decoder.
package decode_window_ctrl_pkg;

    localparam int BUF_BYTES   = 32;
    localparam int FETCH_BYTES = 8;
    localparam int WIN_BYTES   = 15;

    localparam int PTR_W = $clog2(BUF_BYTES);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    // Byte k of the decode window occupies bits [8k:8k+7].
    typedef logic [0:8*WIN_BYTES-1] window_t;

endpackage

// File: rtl/decode_window_ctrl_byte_ring_buffer.sv
// Circular byte store: scatters one fetch chunk per cycle at the write pointer
// and gathers the decode window starting at the read pointer, both modulo depth.
module byte_ring_buffer
    import decode_window_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [PTR_W-1:0]         wr_ptr,
    input  logic [8*FETCH_BYTES-1:0] wr_data,
    input  logic [PTR_W-1:0]         rd_ptr,
    output window_t                  rd_window
);

    logic [7:0] mem [BUF_BYTES];

    // Storage is cleared on reset so the window reads back as zero until refilled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            for (int j = 0; j < FETCH_BYTES; j++) begin
                mem[wr_ptr + PTR_W'(j)] <= wr_data[8*(FETCH_BYTES-1-j) +: 8];
            end
        end
    end

    always_comb begin
        rd_window = '0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            rd_window[8*k +: 8] = mem[rd_ptr + PTR_W'(k)];
        end
    end

endmodule

// File: rtl/decode_window_ctrl.sv
// Fetch/decode byte-stream controller: keeps the ring buffer topped up from
// fetch, presents the oldest bytes to the decoder and retires what it consumes.
module decode_window_ctrl
    import decode_window_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] fetch_addr,
    output logic        fetch_ready,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_data,
    output window_t     dc_bytes,
    output logic [63:0] dc_pc,
    output logic        dc_valid,
    input  logic        dc_accept,
    input  logic [3:0]  dc_len,
    input  logic        dc_invalid,
    output logic        fault,
    output logic [63:0] fault_pc
);

    state_t             state, state_next;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [63:0]        pc, pc_next;
    logic [63:0]        fetch_addr_next;
    logic [63:0]        fault_pc_next;
    logic               enq, deq, take_fault;

    assign fetch_ready = (state == RUN) && (count <= CNT_W'(BUF_BYTES - FETCH_BYTES));
    assign dc_valid    = (state == RUN) && (count >= CNT_W'(WIN_BYTES));
    assign fault       = (state == FAULT);
    assign dc_pc       = pc;

    byte_ring_buffer u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (enq),
        .wr_ptr    (wr_ptr),
        .wr_data   (fetch_data),
        .rd_ptr    (rd_ptr),
        .rd_window (dc_bytes)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            pc         <= '0;
            fetch_addr <= '0;
            fault_pc   <= '0;
        end else begin
            state      <= state_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            count      <= count_next;
            pc         <= pc_next;
            fetch_addr <= fetch_addr_next;
            fault_pc   <= fault_pc_next;
        end
    end

    // A redirect swallows every other same-cycle event; an invalid report
    // blocks retirement but lets a concurrent fetch beat land.
    always_comb begin
        enq        = fetch_valid && fetch_ready && !redirect_valid;
        take_fault = dc_valid && dc_invalid && !redirect_valid;
        deq        = dc_valid && dc_accept && (dc_len != 4'd0) && !dc_invalid && !redirect_valid;

        state_next      = state;
        rd_ptr_next     = rd_ptr;
        wr_ptr_next     = wr_ptr;
        count_next      = count;
        pc_next         = pc;
        fetch_addr_next = fetch_addr;
        fault_pc_next   = fault_pc;

        if (redirect_valid) begin
            state_next      = RUN;
            rd_ptr_next     = '0;
            wr_ptr_next     = '0;
            count_next      = '0;
            pc_next         = redirect_pc;
            fetch_addr_next = redirect_pc;
            fault_pc_next   = '0;
        end else begin
            if (enq) begin
                wr_ptr_next     = wr_ptr + PTR_W'(FETCH_BYTES);
                fetch_addr_next = fetch_addr + 64'(FETCH_BYTES);
            end
            if (deq) begin
                rd_ptr_next = rd_ptr + PTR_W'(dc_len);
                pc_next     = pc + 64'(dc_len);
            end
            count_next = count
                       + (enq ? CNT_W'(FETCH_BYTES) : '0)
                       - (deq ? CNT_W'(dc_len) : '0);
            if (take_fault) begin
                state_next    = FAULT;
                fault_pc_next = pc;
            end
        end
    end

endmodule

// File: tb/tb_decode_window_ctrl.sv
// Scoreboard bench for decode_window_ctrl: a byte-queue reference model predicts
// each cycle's outputs, and a monitor compares them after every clock edge.
`timescale 1ns/1ps
module tb_decode_window_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic [63:0]  fetch_addr;
    logic         fetch_ready;
    logic         fetch_valid;
    logic [63:0]  fetch_data;
    logic [0:119] dc_bytes;
    logic [63:0]  dc_pc;
    logic         dc_valid;
    logic         dc_accept;
    logic [3:0]   dc_len;
    logic         dc_invalid;
    logic         fault;
    logic [63:0]  fault_pc;

    always #5 clk = ~clk;

    decode_window_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .dc_bytes       (dc_bytes),
        .dc_pc          (dc_pc),
        .dc_valid       (dc_valid),
        .dc_accept      (dc_accept),
        .dc_len         (dc_len),
        .dc_invalid     (dc_invalid),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    typedef struct {
        logic [63:0]  fetch_addr;
        logic         fetch_ready;
        logic         dc_valid;
        logic [63:0]  dc_pc;
        logic [119:0] win;
        logic         fault;
        logic [63:0]  fault_pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    logic [7:0]  m_buf[$];
    logic [63:0] m_pc;
    logic [63:0] m_fa;
    logic [63:0] m_fault_pc;
    int          m_mode;

    // Memory image: the byte stored at any address is a fixed function of it.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic [63:0] chunk_at(input logic [63:0] a);
        logic [63:0] c = '0;
        for (int j = 0; j < 8; j++) c = {c[55:0], mem_byte(a + 64'(j))};
        return c;
    endfunction

    function automatic logic [119:0] window_at(input logic [63:0] a);
        logic [119:0] w = '0;
        for (int k = 0; k < 15; k++) w = {w[111:0], mem_byte(a + 64'(k))};
        return w;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.fetch_addr  = m_fa;
        e.fetch_ready = (m_mode == M_RUN) && (m_buf.size() <= 24);
        e.dc_valid    = (m_mode == M_RUN) && (m_buf.size() >= 15);
        e.dc_pc       = m_pc;
        e.win         = '0;
        if (m_buf.size() >= 15)
            for (int k = 0; k < 15; k++) e.win = {e.win[111:0], m_buf[k]};
        e.fault       = (m_mode == M_FAULT);
        e.fault_pc    = m_fault_pc;
        return e;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_pc       = '0;
        m_fa       = '0;
        m_fault_pc = '0;
        m_mode     = M_IDLE;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_fetch_addr"},  128'(fetch_addr),  128'(0));
        checkOutput({tag, "_fetch_ready"}, 128'(fetch_ready), 128'(0));
        checkOutput({tag, "_dc_valid"},    128'(dc_valid),    128'(0));
        checkOutput({tag, "_dc_pc"},       128'(dc_pc),       128'(0));
        checkOutput({tag, "_dc_bytes"},    128'(dc_bytes),    128'(0));
        checkOutput({tag, "_fault"},       128'(fault),       128'(0));
        checkOutput({tag, "_fault_pc"},    128'(fault_pc),    128'(0));
    endtask

    // Drives one cycle of inputs and pushes what the outputs must be after the edge.
    task automatic applyStimulus(input logic redir, input logic [63:0] rpc,
                                 input logic fv, input logic acc,
                                 input logic [3:0] len, input logic inv);
        bit can_fetch;
        bit win_ok;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        fetch_valid    = fv;
        fetch_data     = chunk_at(m_fa);
        dc_accept      = acc;
        dc_len         = len;
        dc_invalid     = inv;
        if (redir) begin
            m_buf.delete();
            m_pc       = rpc;
            m_fa       = rpc;
            m_fault_pc = '0;
            m_mode     = M_RUN;
        end else if (m_mode == M_RUN) begin
            can_fetch = (m_buf.size() <= 24);
            win_ok    = (m_buf.size() >= 15);
            if (fv && can_fetch) begin
                for (int j = 0; j < 8; j++) m_buf.push_back(mem_byte(m_fa + 64'(j)));
                m_fa += 64'd8;
            end
            if (win_ok && inv) begin
                m_mode     = M_FAULT;
                m_fault_pc = m_pc;
            end else if (win_ok && acc && len != 4'd0) begin
                repeat (len) void'(m_buf.pop_front());
                m_pc += 64'(len);
            end
        end
        exp_q.push_back(model_outputs());
    endtask

    task automatic applyRandom(input bit allow_redirect);
        logic       redir;
        logic [63:0] rpc;
        redir = allow_redirect && ($urandom_range(0, 59) == 0);
        rpc   = {$urandom, $urandom};
        applyStimulus(redir, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every pending prediction is compared just after the edge it targets.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("mon_fetch_addr",  128'(fetch_addr),  128'(e.fetch_addr));
                checkOutput("mon_fetch_ready", 128'(fetch_ready), 128'(e.fetch_ready));
                checkOutput("mon_dc_valid",    128'(dc_valid),    128'(e.dc_valid));
                checkOutput("mon_dc_pc",       128'(dc_pc),       128'(e.dc_pc));
                checkOutput("mon_fault",       128'(fault),       128'(e.fault));
                checkOutput("mon_fault_pc",    128'(fault_pc),    128'(e.fault_pc));
                if (e.dc_valid)
                    checkOutput("mon_dc_bytes", 128'(dc_bytes), 128'(e.win));
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_valid    = 1'b0;
        fetch_data     = '0;
        dc_accept      = 1'b0;
        dc_len         = '0;
        dc_invalid     = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("por");
        #1 reset_n = 1'b1;

        $display("[TB] redirect to 0x1000 and first fill");
        applyStimulus(1'b1, 64'h1000, 1'b1, 1'b0, 4'd0, 1'b0);
        afterEdge();
        checkOutput("fill_fa0", 128'(fetch_addr), 128'(64'h1000));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        afterEdge();
        checkOutput("fill_fa1",    128'(fetch_addr), 128'(64'h1008));
        checkOutput("fill_valid0", 128'(dc_valid),   128'(0));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        afterEdge();
        checkOutput("fill_valid1", 128'(dc_valid), 128'(1));
        checkOutput("fill_pc",     128'(dc_pc),    128'(64'h1000));
        checkOutput("fill_bytes",  128'(dc_bytes), 128'(window_at(64'h1000)));

        $display("[TB] steady stream with retires");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd3, 1'b0);
        afterEdge();
        checkOutput("stream_pc3", 128'(dc_pc), 128'(64'h1003));
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd15, 1'b0);
        afterEdge();
        checkOutput("stream_pc15", 128'(dc_pc), 128'(64'h1012));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd1, 1'b0);
        afterEdge();
        checkOutput("stream_pc1",   128'(dc_pc),    128'(64'h1013));
        checkOutput("stream_bytes", 128'(dc_bytes), 128'(window_at(64'h1013)));

        $display("[TB] decoder stall until buffer full");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd5, 1'b0);
        afterEdge();
        checkOutput("full_ready24", 128'(fetch_ready), 128'(1));
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        afterEdge();
        checkOutput("full_ready32", 128'(fetch_ready), 128'(0));
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        afterEdge();
        checkOutput("full_fa",    128'(fetch_addr), 128'(64'h1038));
        checkOutput("full_bytes", 128'(dc_bytes),   128'(window_at(64'h1018)));
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd9, 1'b0);
        afterEdge();
        checkOutput("drain_ready", 128'(fetch_ready), 128'(1));
        checkOutput("drain_pc",    128'(dc_pc),       128'(64'h1021));

        $display("[TB] invalid opcode fault");
        applyStimulus(1'b1, 64'h2000, 1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd4, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd3, 1'b1);
        afterEdge();
        checkOutput("fault_flag",  128'(fault),       128'(1));
        checkOutput("fault_pc",    128'(fault_pc),    128'(64'h2004));
        checkOutput("fault_valid", 128'(dc_valid),    128'(0));
        checkOutput("fault_ready", 128'(fetch_ready), 128'(0));
        checkOutput("fault_fa",    128'(fetch_addr),  128'(64'h2020));
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 64'h3000, 1'b1, 1'b1, 4'd2, 1'b1);
        afterEdge();
        checkOutput("recover_fault", 128'(fault),      128'(0));
        checkOutput("recover_fpc",   128'(fault_pc),   128'(0));
        checkOutput("recover_fa",    128'(fetch_addr), 128'(64'h3000));

        $display("[TB] redirect colliding with fetch and accept");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 64'h4000, 1'b1, 1'b1, 4'd5, 1'b0);
        afterEdge();
        checkOutput("collide_pc",    128'(dc_pc),       128'(64'h4000));
        checkOutput("collide_valid", 128'(dc_valid),    128'(0));
        checkOutput("collide_fa",    128'(fetch_addr),  128'(64'h4000));
        checkOutput("collide_ready", 128'(fetch_ready), 128'(1));

        $display("[TB] randomized traffic");
        repeat (400) applyRandom(1'b1);

        $display("[TB] asynchronous reset mid-stream");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("async");
        #1 reset_n = 1'b1;
        model_reset();
        repeat (10) applyRandom(1'b0);
        applyStimulus(1'b1, 64'h5000, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (300) applyRandom(1'b1);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
